pc_sequencer: RTL



---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_ras.sv | 65 ++++++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-address sequencer: FSM states, next-PC selects
// and the return-address stack depth.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_RET    = 3'd4
    } sel_t;

    localparam int RAS_DEPTH = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/fetch-address bundle between decode/execute and the PC sequencer.
// call/ret exist only when PC_SEQ_RAS_EN is defined.
interface pc_sequencer_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_offset;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            halt;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            halted;
`ifdef PC_SEQ_RAS_EN
    logic            call;
    logic            ret;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               halt, resume, call, ret,
        input  pc, pc_valid, halted
    );
    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               halt, resume, call, ret,
        output pc, pc_valid, halted
    );
`else
    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               halt, resume,
        input  pc, pc_valid, halted
    );
    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               halt, resume,
        output pc, pc_valid, halted
    );
`endif
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty yields RESET_VECTOR and leaves the depth at zero.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top
);
    localparam int             PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W:0]   DEPTH_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   DEPTH_MAX = (PTR_W + 1)'(RAS_DEPTH);

    logic [PC_W-1:0]  entry_r [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   depth_r;
    logic [PTR_W-1:0] top_ptr_s;

    assign top_ptr_s = wr_ptr_r - PTR_ONE;

    // Top-of-stack read, falling back to the reset vector when empty
    always_comb begin
        top = RESET_VECTOR;
        if (depth_r != DEPTH_ZERO) begin
            top = entry_r[top_ptr_s];
        end else begin
            top = RESET_VECTOR;
        end
    end

    // Write pointer and depth bookkeeping; pop takes precedence over push
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            depth_r  <= DEPTH_ZERO;
        end else if (pop) begin
            if (depth_r != DEPTH_ZERO) begin
                wr_ptr_r <= top_ptr_s;
                depth_r  <= depth_r - DEPTH_ONE;
            end
        end else if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (depth_r != DEPTH_MAX) begin
                depth_r <= depth_r + DEPTH_ONE;
            end
        end
    end

    // Entry storage, written at the pointer which also marks the oldest entry when full
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            entry_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the fetch path: BOOT/RUN/HALT FSM plus next-PC mux.
// Define PC_SEQ_RAS_EN to add call/ret with a 4-entry return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.slave     bus
);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_r;
    state_t          state_s;
    sel_t            sel_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] pc_branch_s;
    logic [PC_W-1:0] ras_top_s;
    logic            pc_valid_r;
    logic            halted_r;
    logic            ras_push_s;
    logic            ras_pop_s;

    assign pc_inc_s    = pc_r + PC_ONE;
    // Same-width add wraps exactly as a sign-extended offset would
    assign pc_branch_s = pc_r + bus.branch_offset;

`ifdef PC_SEQ_RAS_EN
    pc_ras #(
        .PC_W         (PC_W),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (pc_inc_s),
        .top       (ras_top_s)
    );
`else
    assign ras_top_s = pc_r;
`endif

    // Next-state and next-PC select with the redirect priority order
    always_comb begin
        state_s    = state_r;
        sel_s      = SEL_HOLD;
        ras_push_s = 1'b0;
        ras_pop_s  = 1'b0;
        case (state_r)
            BOOT: begin
                state_s = RUN;
                sel_s   = SEL_HOLD;
            end
            RUN: begin
                if (bus.halt) begin
                    state_s = HALT;
                    sel_s   = SEL_HOLD;
                end else if (bus.stall) begin
                    sel_s = SEL_HOLD;
`ifdef PC_SEQ_RAS_EN
                end else if (bus.ret) begin
                    sel_s     = SEL_RET;
                    ras_pop_s = 1'b1;
                end else if (bus.call) begin
                    sel_s      = SEL_JUMP;
                    ras_push_s = 1'b1;
`endif
                end else if (bus.jump) begin
                    sel_s = SEL_JUMP;
                end else if (bus.branch_taken) begin
                    sel_s = SEL_BRANCH;
                end else begin
                    sel_s = SEL_INC;
                end
            end
            HALT: begin
                if (bus.resume && !bus.halt) begin
                    state_s = RUN;
                    sel_s   = SEL_INC;
                end else begin
                    state_s = HALT;
                    sel_s   = SEL_HOLD;
                end
            end
            default: begin
                state_s = BOOT;
                sel_s   = SEL_HOLD;
            end
        endcase
    end

    // Next-PC mux
    always_comb begin
        pc_s = pc_r;
        case (sel_s)
            SEL_INC:    pc_s = pc_inc_s;
            SEL_BRANCH: pc_s = pc_branch_s;
            SEL_JUMP:   pc_s = bus.jump_target;
            SEL_RET:    pc_s = ras_top_s;
            SEL_HOLD:   pc_s = pc_r;
            default:    pc_s = pc_r;
        endcase
    end

    // State, PC and status registers; status is decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= BOOT;
            pc_r       <= RESET_VECTOR;
            pc_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pc_valid_r <= (state_s == RUN);
            halted_r   <= (state_s == HALT);
        end
    end

    assign bus.pc       = pc_r;
    assign bus.pc_valid = pc_valid_r;
    assign bus.halted   = halted_r;

endmodule
